axi_read_arbiter: RTL
=====================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of request addresses.
REQ-002 Parameter DATA_WIDTH, default 32, width of read data.
REQ-003 Parameter LEN_WIDTH, default 8, burst length field; value N means N+1 beats.
REQ-004 Port clk  input  1  sole clock, all state on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Ports s0_read_req / s1_read_req  input  1  requester 0 (icache) / 1 (dcache) request, level-held.
REQ-007 Ports s0_read_addr / s1_read_addr  input  ADDR_WIDTH  burst start address, stable while read_req high.
REQ-008 Ports s0_read_len / s1_read_len  input  LEN_WIDTH  burst length, stable while read_req high.
REQ-009 Ports s0_read_ready / s1_read_ready  output  1  one-cycle beat-valid strobe to owner.
REQ-010 Ports s0_read_done / s1_read_done  output  1  one-cycle burst-complete strobe to owner.
REQ-011 Ports s0_read_data / s1_read_data  output  DATA_WIDTH  beat data to owner.
REQ-012 Ports m_read_req  output  1, m_read_addr  output  ADDR_WIDTH, m_read_len  output  LEN_WIDTH  request to AXI read master.
REQ-013 Ports m_read_ready  input  1, m_read_done  input  1, m_read_data  input  DATA_WIDTH  returns from AXI read master.
REQ-014 Ports busy  output  1 (burst in flight), owner  output  1 (current grantee), proto_err  output  1 (sticky beat-count error).

Function
REQ-015 State machine SHALL have states IDLE, BURST, RELEASE.
REQ-016 IDLE: if any sN_read_req high, SHALL grant one requester and enter BURST next cycle; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: with both requesting, grant the port not granted last; with one requesting, grant it.
REQ-018 On grant, m_read_addr/m_read_len SHALL be registered from the winner and m_read_req driven high from the next cycle, held constant through BURST.
REQ-019 Latency: sN_read_req rising in IDLE at cycle t -> m_read_req high at t+1.
REQ-020 In BURST, m_read_ready, m_read_data, m_read_done SHALL route combinationally to owner's sN ports only; non-owner read_ready/read_done SHALL be 0 and read_data 0.
REQ-021 Beat counter (LEN_WIDTH+1 bits) SHALL clear on grant and increment on each m_read_ready in BURST.
REQ-022 m_read_done SHALL coincide with the last m_read_ready; on m_read_done, state -> RELEASE and m_read_req low from next cycle.
REQ-023 On m_read_done, if beats counted including that beat != m_read_len+1, proto_err SHALL set and hold until reset.
REQ-024 RELEASE SHALL last exactly one cycle then go IDLE; requesters SHALL drop read_req the cycle after read_done, so no stale re-grant occurs.
REQ-025 The last-grant pointer SHALL update only at grant time.
REQ-026 m_read_ready/m_read_done arriving in IDLE or RELEASE SHALL be ignored, not forwarded, and set proto_err.
REQ-027 A requester dropping read_req mid-BURST SHALL NOT abort the burst; it completes and returns to IDLE.
REQ-028 busy SHALL be high in BURST and RELEASE; owner SHALL hold last grantee value outside BURST.

Reset
REQ-029 rst high SHALL force state IDLE, m_read_req 0, m_read_addr 0, m_read_len 0, busy 0, owner 0, proto_err 0, beat counter 0, and last-grant pointer such that port 0 wins the first tie.
REQ-030 Reset mid-burst SHALL abandon the burst immediately; all sN strobes 0 while rst high and first cycle after.

Verification
REQ-031 Single: s0 req addr 0x1000 len 3 -> m_read_req at t+1 with 0x1000/3; 4 beats forwarded to s0 only; s0_read_done on 4th; m_read_req low next cycle.
REQ-032 Tie: s0 and s1 request together from reset -> s0 granted first, s1 granted in IDLE after RELEASE; next tie grants s0 again.
REQ-033 Starvation: s1 held continuously, s0 re-requests after each burst -> grants alternate s0,s1,s0,s1.
REQ-034 Protocol error: len 3, master gives done on 2nd beat -> proto_err 1 and sticky; state returns IDLE via RELEASE.
REQ-035 Stray strobe: m_read_ready pulse in IDLE -> no sN strobe, proto_err 1.
REQ-036 Reset at beat 2 of 4 -> all outputs reset values; fresh s1 request afterward completes normally.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-port round-robin arbiter in front of one AXI read master
module axi_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    // requester 0 (icache)
    input  logic                  s0_read_req,
    input  logic [ADDR_WIDTH-1:0] s0_read_addr,
    input  logic [LEN_WIDTH-1:0]  s0_read_len,
    output logic                  s0_read_ready,
    output logic                  s0_read_done,
    output logic [DATA_WIDTH-1:0] s0_read_data,

    // requester 1 (dcache)
    input  logic                  s1_read_req,
    input  logic [ADDR_WIDTH-1:0] s1_read_addr,
    input  logic [LEN_WIDTH-1:0]  s1_read_len,
    output logic                  s1_read_ready,
    output logic                  s1_read_done,
    output logic [DATA_WIDTH-1:0] s1_read_data,

    // shared AXI read master
    output logic                  m_read_req,
    output logic [ADDR_WIDTH-1:0] m_read_addr,
    output logic [LEN_WIDTH-1:0]  m_read_len,
    input  logic                  m_read_ready,
    input  logic                  m_read_done,
    input  logic [DATA_WIDTH-1:0] m_read_data,

    // status
    output logic                  busy,
    output logic                  owner,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    // Port granted most recently; the other port wins the next tie.
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  req_q, req_d;
    logic [LEN_WIDTH:0]    cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  grant_port;
    logic [LEN_WIDTH:0]    beats_total;
    logic [LEN_WIDTH:0]    beats_expected;
    logic                  in_burst;

    // Round-robin pick: a lone requester always wins, a tie goes away from last_q.
    always_comb begin
        grant_port = 1'b0;
        if (s0_read_req && s1_read_req) begin
            grant_port = ~last_q;
        end else if (s1_read_req) begin
            grant_port = 1'b1;
        end
    end

    // Beat total including a beat that arrives together with done.
    assign beats_total    = cnt_q + {{LEN_WIDTH{1'b0}}, m_read_ready};
    assign beats_expected = {1'b0, len_q} + {{LEN_WIDTH{1'b0}}, 1'b1};

    // Next-state logic: grant in IDLE, count beats in BURST, one-cycle RELEASE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                // Master strobes with no burst outstanding are dropped and flagged.
                if (m_read_ready || m_read_done) begin
                    err_d = 1'b1;
                end
                if (s0_read_req || s1_read_req) begin
                    state_d = ST_BURST;
                    owner_d = grant_port;
                    last_d  = grant_port;
                    addr_d  = grant_port ? s1_read_addr : s0_read_addr;
                    len_d   = grant_port ? s1_read_len  : s0_read_len;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end
            end

            ST_BURST: begin
                if (m_read_ready) begin
                    cnt_d = cnt_q + {{LEN_WIDTH{1'b0}}, 1'b1};
                end
                if (m_read_done) begin
                    state_d = ST_RELEASE;
                    req_d   = 1'b0;
                    if (beats_total != beats_expected) begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                // Gives the finished requester a cycle to drop its request.
                if (m_read_ready || m_read_done) begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and request registers; reset leaves last_q at 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            len_q   <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Return path is steered only while a burst is in flight, to the owner only.
    assign in_burst = (state_q == ST_BURST);

    assign s0_read_ready = in_burst && !owner_q && m_read_ready;
    assign s0_read_done  = in_burst && !owner_q && m_read_done;
    assign s0_read_data  = (in_burst && !owner_q) ? m_read_data : '0;

    assign s1_read_ready = in_burst && owner_q && m_read_ready;
    assign s1_read_done  = in_burst && owner_q && m_read_done;
    assign s1_read_data  = (in_burst && owner_q) ? m_read_data : '0;

    assign m_read_req  = req_q;
    assign m_read_addr = addr_q;
    assign m_read_len  = len_q;

    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;
    assign proto_err = err_q;

endmodule
